// File: rtl/timer_alarm_ctrl.sv
// timer_alarm_ctrl: slot-bus MMIO block with N_CH alarm channels on one shared prescaled tick
//
// Ports:
//   clk      system clock, all state on the rising edge
//   reset    synchronous active-high reset, clears every register
//   cs       slot select
//   read     read strobe (reads have no side effects)
//   write    write strobe, a write happens when cs && write
//   addr     word address within the slot
//   wr_data  write data
//   rd_data  combinational read data for addr, unmapped addresses read 0
//   irq      registered level interrupt, |(pending & irq_en)
//
// Map: 0 CTRL {psc_clr, go}, 1 PRESCALE, 2 PENDING (W1C), 3 IRQ_EN,
//      channel i at 4*(i+1): +0 LOAD, +1 CCTRL {restart, periodic, en}, +2 COUNT (RO)
module timer_alarm_ctrl #(
    parameter int N_CH  = 4,
    parameter int PSC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);
    typedef enum logic {IDLE, RUN} ch_state_t;

    ch_state_t          st_q       [N_CH];
    ch_state_t          st_d       [N_CH];
    logic               periodic_q [N_CH];
    logic               periodic_d [N_CH];
    logic [31:0]        load_q     [N_CH];
    logic [31:0]        load_d     [N_CH];
    logic [31:0]        count_q    [N_CH];
    logic [31:0]        count_d    [N_CH];
    logic               cctrl_wr   [N_CH];
    logic               restart    [N_CH];
    logic [N_CH-1:0]    pend_q, pend_d, irq_en_q, irq_en_d, expire;
    logic               go_q, go_d;
    logic [PSC_W-1:0]   psc_q, psc_d, psc_cnt_q, psc_cnt_d;
    logic               wr, psc_force, tick;
    logic               unused_read;

    assign unused_read = read;
    assign wr = cs && write;

    always_comb begin
        // Any PRESCALE write or a psc_clr strobe restarts the prescaler and eats that cycle's tick
        psc_force = wr && (addr == 5'd1 || (addr == 5'd0 && wr_data[1]));
        tick      = go_q && !psc_force && psc_cnt_q == psc_q;
        psc_cnt_d = psc_force ? '0 : !go_q ? psc_cnt_q :
                    (psc_cnt_q == psc_q) ? '0 : psc_cnt_q + PSC_W'(1);
        go_d      = (wr && addr == 5'd0) ? wr_data[0] : go_q;
        psc_d     = (wr && addr == 5'd1) ? wr_data[PSC_W-1:0] : psc_q;
        irq_en_d  = (wr && addr == 5'd3) ? wr_data[N_CH-1:0] : irq_en_q;
        expire    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cctrl_wr[i]   = wr && addr == 5'(4 * i + 5);
            // Explicit restart bit or an IDLE->RUN enable both reload the counter
            restart[i]    = cctrl_wr[i] && (wr_data[2] || (wr_data[0] && st_q[i] == IDLE));
            // Restart wins over a coincident tick, so no expiry on that cycle
            expire[i]     = !restart[i] && st_q[i] == RUN && tick && count_q[i] == 32'd0;
            load_d[i]     = (wr && addr == 5'(4 * i + 4)) ? wr_data : load_q[i];
            periodic_d[i] = cctrl_wr[i] ? wr_data[1] : periodic_q[i];
            st_d[i]       = cctrl_wr[i] ? (wr_data[0] ? RUN : IDLE) :
                            (expire[i] && !periodic_q[i]) ? IDLE : st_q[i];
            count_d[i]    = restart[i] ? load_q[i] :
                            expire[i] ? (periodic_q[i] ? load_q[i] : count_q[i]) :
                            (st_q[i] == RUN && tick) ? count_q[i] - 32'd1 : count_q[i];
        end
        // A new expiry overrides a W1C of the same bit
        pend_d = ((wr && addr == 5'd2) ? (pend_q & ~wr_data[N_CH-1:0]) : pend_q) | expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            go_q      <= 1'b0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            pend_q    <= '0;
            irq_en_q  <= '0;
            irq       <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]       <= IDLE;
                periodic_q[i] <= 1'b0;
                load_q[i]     <= '0;
                count_q[i]    <= '0;
            end
        end else begin
            go_q      <= go_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            pend_q    <= pend_d;
            irq_en_q  <= irq_en_d;
            irq       <= |(pend_q & irq_en_q);
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]       <= st_d[i];
                periodic_q[i] <= periodic_d[i];
                load_q[i]     <= load_d[i];
                count_q[i]    <= count_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr == 5'd0) rd_data = {31'b0, go_q};
        if (addr == 5'd1) rd_data = 32'(psc_q);
        if (addr == 5'd2) rd_data = 32'(pend_q);
        if (addr == 5'd3) rd_data = 32'(irq_en_q);
        for (int i = 0; i < N_CH; i++) begin
            if (addr == 5'(4 * i + 4)) rd_data = load_q[i];
            if (addr == 5'(4 * i + 5)) rd_data = {30'b0, periodic_q[i], st_q[i] == RUN};
            if (addr == 5'(4 * i + 6)) rd_data = count_q[i];
        end
    end
endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// tb_timer_alarm_ctrl: scoreboard bench for timer_alarm_ctrl
module tb_timer_alarm_ctrl;
    logic        clk = 1'b0;
    logic        reset, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        irq;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          c1, c2, c3, c4, c5;

    timer_alarm_ctrl #(.N_CH(4), .PSC_W(16)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] got);
        if (exp_q.size() == 0) chk("scoreboard_underflow", got, ~got);
        else chk(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic rdchk(input logic [4:0] a, input logic [31:0] want, input string tag);
        addr = a;
        read = 1'b1;
        push_exp(tag, want);
        #1;
        observe(rd_data);
        read = 1'b0;
    endtask

    task automatic irqchk(input logic want, input string tag);
        push_exp(tag, {31'b0, want});
        #1;
        observe({31'b0, irq});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic wait_pend(input int b, output int c);
        c = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            addr = 5'd2;
            #1;
            if (rd_data[b]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("pend_timeout", {31'b0, rd_data[b]}, 32'd1);
    endtask

    task automatic period_chk(input int a, input int b, input int want, input string tag);
        push_exp(tag, 32'(want));
        observe(32'(b - a));
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        repeat (2) step();
        reset = 1'b0;
        rdchk(5'd0, 0, "rst_ctrl");
        rdchk(5'd1, 0, "rst_psc");
        rdchk(5'd2, 0, "rst_pending");
        rdchk(5'd3, 0, "rst_irq_en");
        rdchk(5'd4, 0, "rst_load0");
        rdchk(5'd6, 0, "rst_count0");
        irqchk(1'b0, "rst_irq");

        // periodic channel 0, psc=3, LOAD=4 -> expiry every 20 clk
        wr(5'd1, 3); wr(5'd4, 4); wr(5'd3, 1); wr(5'd5, 3); wr(5'd0, 1);
        wait_pend(0, c1);
        irqchk(1'b0, "t1_irq_lag");
        step();
        irqchk(1'b1, "t1_irq_rise");
        wr(5'd2, 1);
        wait_pend(0, c2);
        period_chk(c1, c2, 20, "t1_period");
        irqchk(1'b0, "t1_irq_lag2");
        step();
        irqchk(1'b1, "t1_irq_rise2");

        // W1C landing on the expiry cycle: set wins
        while (cyc < c2 + 19) step();
        wr(5'd2, 1);
        rdchk(5'd2, 1, "t3_set_wins");
        irqchk(1'b1, "t3_irq_held");
        wr(5'd2, 1);
        rdchk(5'd2, 0, "t3_cleared");
        irqchk(1'b1, "t3_irq_before_drop");
        step();
        irqchk(1'b0, "t3_irq_dropped");

        // LOAD rewrite takes effect only at next reload
        wait_pend(0, c3);
        wr(5'd4, 10);
        wr(5'd2, 1);
        wait_pend(0, c4);
        period_chk(c3, c4, 20, "t5_period_unchanged");
        wr(5'd2, 1);
        wait_pend(0, c5);
        period_chk(c4, c5, 44, "t5_period_new");
        wr(5'd5, 7);
        rdchk(5'd6, 10, "t5_restart_count");
        rdchk(5'd5, 3, "t5_cctrl_read");

        // go=0 freezes the count; resume decrements psc+1 clk after go=1
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 100 && !seen; k++) begin
                step();
                addr = 5'd6;
                #1;
                seen = (rd_data == 32'd7);
            end
            if (!seen) chk("t4_cnt7_timeout", rd_data, 32'd7);
        end
        wr(5'd0, 2);
        repeat (50) step();
        rdchk(5'd6, 7, "t4_frozen");
        rdchk(5'd0, 0, "t4_ctrl_go0");
        wr(5'd0, 1);
        repeat (3) step();
        rdchk(5'd6, 7, "t4_not_yet");
        step();
        rdchk(5'd6, 6, "t4_resumed");

        // one-shot channel 1, psc=0, LOAD=2
        wr(5'd5, 0); wr(5'd1, 0); wr(5'd2, 15); wr(5'd3, 2); wr(5'd8, 2);
        wr(5'd9, 1);
        rdchk(5'd10, 2, "t2_count_load");
        step();
        rdchk(5'd10, 1, "t2_count_1");
        step();
        rdchk(5'd10, 0, "t2_count_0");
        rdchk(5'd2, 0, "t2_no_pend_yet");
        step();
        rdchk(5'd2, 2, "t2_expired");
        rdchk(5'd9, 0, "t2_en_cleared");
        rdchk(5'd10, 0, "t2_count_stays0");
        irqchk(1'b0, "t2_irq_lag");
        step();
        irqchk(1'b1, "t2_irq_rise");
        wr(5'd2, 2);
        repeat (10) step();
        rdchk(5'd2, 0, "t2_no_second");
        rdchk(5'd10, 0, "t2_count_idle");

        // LOAD=0, psc=0, periodic: expiry every clk
        wr(5'd13, 3);
        rdchk(5'd14, 0, "b_count0");
        rdchk(5'd2, 0, "b_pend_before");
        step();
        rdchk(5'd2, 4, "b_pend_first");
        wr(5'd2, 4);
        rdchk(5'd2, 4, "b_pend_every_clk");
        wr(5'd3, 4);
        step();
        irqchk(1'b1, "t6_irq_before_reset");

        // reset mid-run with an in-flight write
        reset = 1'b1; cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'd5;
        step();
        reset = 1'b0; cs = 1'b0; write = 1'b0;
        irqchk(1'b0, "t6_irq");
        rdchk(5'd2, 0, "t6_pending");
        rdchk(5'd6, 0, "t6_count0");
        rdchk(5'd10, 0, "t6_count1");
        rdchk(5'd14, 0, "t6_count2");
        rdchk(5'd18, 0, "t6_count3");
        rdchk(5'd0, 0, "t6_ctrl");
        rdchk(5'd31, 0, "t6_unmapped");
        rdchk(5'd1, 0, "t6_write_lost");
        rdchk(5'd4, 0, "t6_load0");
        step();
        rdchk(5'd2, 0, "t6_pending_idle");

        if (exp_q.size() != 0) chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
